// File: rtl/dot_product2x2_pkg.sv
// rtl/dot_product2x2_pkg.sv - shared constants for the dot_product2x2 block
package dot_product2x2_pkg;

  localparam int OPERAND_W = 2;
  localparam int PRODUCT_W = 4;

  typedef logic state_t;
  localparam state_t ST_ACCUM = 1'b0;
  localparam state_t ST_DONE  = 1'b1;

endpackage

// File: rtl/multiplier2x2.sv
// rtl/multiplier2x2.sv - combinational 2x2-bit unsigned multiplier
module multiplier2x2
  import dot_product2x2_pkg::*;
(
  output logic [PRODUCT_W-1:0] result,
  input  logic [OPERAND_W-1:0] multiplicand,
  input  logic [OPERAND_W-1:0] multiplier
);

  assign result = {2'b00, multiplicand} * {2'b00, multiplier};

endmodule

// File: rtl/dot_product2x2.sv
// rtl/dot_product2x2.sv - streaming 2x2 dot-product accumulator with valid/ready result
// Optional clamp-on-overflow accumulator: DOT_PRODUCT2X2_SATURATE_EN
module dot_product2x2
  import dot_product2x2_pkg::*;
#(
  parameter  int ACC_W   = 8,
  parameter  int MAX_LEN = 16,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [OPERAND_W-1:0] multiplicand,
  input  logic [OPERAND_W-1:0] multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_overflow
);

  state_t               state;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  logic [PRODUCT_W-1:0] product;
  logic [ACC_W:0]       sum_next;
  logic [ACC_W-1:0]     acc_next;
  logic                 ovf_next;
  logic                 close_grp;

  multiplier2x2 u_mult (
    .result       (product),
    .multiplicand (multiplicand),
    .multiplier   (multiplier)
  );

  assign in_ready  = (state == ST_ACCUM);
  assign sum_next  = {1'b0, acc} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, product};
  assign ovf_next  = ovf | sum_next[ACC_W];
  assign close_grp = in_last || (cnt == CNT_W'(MAX_LEN - 1));

`ifdef DOT_PRODUCT2X2_SATURATE_EN
  // Once the group has overflowed the accumulator is pinned at full scale.
  assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum_next[ACC_W-1:0];
`else
  assign acc_next = sum_next[ACC_W-1:0];
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_ACCUM;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (state == ST_ACCUM) begin
      if (in_valid) begin
        if (close_grp) begin
          out_sum      <= acc_next;
          out_count    <= cnt + CNT_W'(1);
          out_overflow <= ovf_next;
          out_valid    <= 1'b1;
          state        <= ST_DONE;
          acc          <= '0;
          cnt          <= '0;
          ovf          <= 1'b0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          ovf <= ovf_next;
        end
      end
    end else begin
      // Result is held untouched until the consumer takes it.
      if (out_ready) begin
        out_valid <= 1'b0;
        state     <= ST_ACCUM;
      end
    end
  end

endmodule
